// File: rtl/clk_rst_seq.sv
// Power-on sequencer behind the system PLL: debounces lock into a synchronous
// system reset, re-kicks a PLL that never locks, and produces the CPU clock enable.
module clk_rst_seq #(
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int CE_DIV         = 25,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       cpu_ce,
  output logic [1:0] state_dbg
);
  localparam int M1   = (STABLE_CYCLES > LOCK_TIMEOUT) ? STABLE_CYCLES : LOCK_TIMEOUT;
  localparam int M2   = (HOLD_CYCLES > PLL_RST_CYCLES) ? HOLD_CYCLES : PLL_RST_CYCLES;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int CEW  = $clog2(CE_DIV);

  // Low two bits double as the debug encoding; PLLRST is folded onto 0.
  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_STAB   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_PLLRST = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CEW-1:0] ce_cnt_q, ce_cnt_d;
  logic           lk_meta_q, lk_q;
  logic           pll_rst_q, pll_rst_d;
  logic           sys_reset_q, sys_reset_d;
  logic           cpu_ce_q, cpu_ce_d;
  logic [1:0]     state_dbg_q, state_dbg_d;
  logic           run_stay;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_WAIT: begin
        if (lk_q) begin
          state_d = ST_STAB;
          cnt_d   = CW'(STABLE_CYCLES - 1);
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d = ST_PLLRST;
          cnt_d   = CW'(PLL_RST_CYCLES - 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PLLRST: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STAB: begin
        if (!lk_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (!lk_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RUN: begin
        if (!lk_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
    // Soft reset skips the PLL and stabilize phases; lock loss still takes priority.
    if (soft_rst && lk_q && state_q != ST_PLLRST) begin
      state_d = ST_HOLD;
      cnt_d   = CW'(HOLD_CYCLES - 1);
    end
  end

  always_comb begin
    run_stay    = (state_q == ST_RUN) && (state_d == ST_RUN);
    ce_cnt_d    = '0;
    cpu_ce_d    = 1'b0;
    if (run_stay) begin
      cpu_ce_d = (ce_cnt_q == CEW'(CE_DIV - 1));
      ce_cnt_d = cpu_ce_d ? '0 : ce_cnt_q + CEW'(1);
    end
    pll_rst_d   = (state_d == ST_PLLRST);
    sys_reset_d = (state_d != ST_RUN);
    state_dbg_d = (state_d == ST_PLLRST) ? 2'd0 : state_d[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_q   <= 1'b0;
      lk_q        <= 1'b0;
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      ce_cnt_q    <= '0;
      pll_rst_q   <= 1'b0;
      sys_reset_q <= 1'b1;
      cpu_ce_q    <= 1'b0;
      state_dbg_q <= 2'd0;
    end else begin
      lk_meta_q   <= pll_locked;
      lk_q        <= lk_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ce_cnt_q    <= ce_cnt_d;
      pll_rst_q   <= pll_rst_d;
      sys_reset_q <= sys_reset_d;
      cpu_ce_q    <= cpu_ce_d;
      state_dbg_q <= state_dbg_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign cpu_ce    = cpu_ce_q;
  assign state_dbg = state_dbg_q;
endmodule
